parking_slot_manager: RTL and testbench

//  Parametrised N-slot parking occupancy and billing engine; successor to the 3-car enter/exit block.

---
 rtl/parking_slot_manager_if.sv | 35 +++
 rtl/parking_slot_manager.sv | 144 ++++++++++++++
 tb/tb_parking_slot_manager.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/parking_slot_manager_if.sv
// Bus between the gate/keypad controller (master) and the parking slot manager (slave).
// Carries the request strobes, slot select and all registered status/billing outputs.
interface parking_slot_manager_if #(
  parameter int NUM_SLOTS = 3,
  parameter int COST_W    = 16
);
  localparam int OCC_W = $clog2(NUM_SLOTS + 1);

  logic                 tick;
  logic                 car_enter;
  logic                 car_exit;
  logic [NUM_SLOTS-1:0] slot_sel;
  logic                 clr_revenue;
  logic [NUM_SLOTS-1:0] slot_state;
  logic [OCC_W-1:0]     occupancy;
  logic                 full;
  logic                 empty;
  logic                 cost_valid;
  logic [COST_W-1:0]    current_cost;
  logic [COST_W-1:0]    revenue_total;
  logic                 err;
  logic [1:0]           err_code;

  modport master (
    output tick, car_enter, car_exit, slot_sel, clr_revenue,
    input  slot_state, occupancy, full, empty, cost_valid, current_cost,
           revenue_total, err, err_code
  );

  modport slave (
    input  tick, car_enter, car_exit, slot_sel, clr_revenue,
    output slot_state, occupancy, full, empty, cost_valid, current_cost,
           revenue_total, err, err_code
  );
endinterface

// File: rtl/parking_slot_manager.sv
// N-slot parking occupancy and billing engine: tracks per-slot parked ticks,
// bills a saturating fee on exit and keeps a saturating revenue total.
module parking_slot_manager #(
  parameter int NUM_SLOTS = 3,
  parameter int DUR_W     = 10,
  parameter int COST_W    = 16,
  parameter int RATE      = 1,
  parameter int BASE_FEE  = 0
) (
  input logic                   clk,
  input logic                   reset,
  parking_slot_manager_if.slave bus
);
  localparam int                OCC_W    = $clog2(NUM_SLOTS + 1);
  localparam logic [DUR_W-1:0]  DUR_MAX  = '1;
  localparam logic [63:0]       COST_MAX = (64'd1 << COST_W) - 64'd1;
  localparam logic [OCC_W-1:0]  OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(NUM_SLOTS);

  typedef enum logic [1:0] {
    ERR_BOTH     = 2'd0,
    ERR_SEL      = 2'd1,
    ERR_OCCUPIED = 2'd2,
    ERR_FREE     = 2'd3
  } err_code_e;

  logic [NUM_SLOTS-1:0] r_slotState;
  logic [OCC_W-1:0]     r_occupancy;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_costValid;
  logic [COST_W-1:0]    r_currentCost;
  logic [COST_W-1:0]    r_revenueTotal;
  logic                 r_err;
  err_code_e            r_errCode;
  logic [DUR_W-1:0]     r_dur [NUM_SLOTS];

  logic                 w_selOccupied;
  logic                 w_reject;
  err_code_e            w_errCause;
  logic                 w_enterOk;
  logic                 w_exitOk;
  logic [DUR_W-1:0]     w_selDur;
  logic [63:0]          w_costFull;
  logic [COST_W-1:0]    w_cost;
  logic [COST_W:0]      w_revSum;
  logic [COST_W-1:0]    w_revNext;
  logic [OCC_W-1:0]     w_occNext;

  // Request validation; the if-chain order encodes the error priority.
  always_comb begin
    w_selOccupied = |(bus.slot_sel & r_slotState);
    w_reject      = 1'b1;
    w_errCause    = ERR_BOTH;
    if (bus.car_enter && bus.car_exit) begin
      w_errCause = ERR_BOTH;
    end else if ((bus.car_enter || bus.car_exit) && !$onehot(bus.slot_sel)) begin
      w_errCause = ERR_SEL;
    end else if (bus.car_enter && w_selOccupied) begin
      w_errCause = ERR_OCCUPIED;
    end else if (bus.car_exit && !w_selOccupied) begin
      w_errCause = ERR_FREE;
    end else begin
      w_reject = 1'b0;
    end
    w_enterOk = bus.car_enter & ~w_reject;
    w_exitOk  = bus.car_exit & ~w_reject;
  end

  // Fee uses the pre-tick duration of the exiting slot, evaluated wide before saturating.
  always_comb begin
    w_selDur = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_selDur = w_selDur | (bus.slot_sel[i] ? r_dur[i] : '0);
    end
    w_costFull = 64'(w_selDur) * 64'(RATE) + 64'(BASE_FEE);
    w_cost     = (w_costFull > COST_MAX) ? '1 : w_costFull[COST_W-1:0];
    w_revSum   = {1'b0, r_revenueTotal} + {1'b0, w_cost};
    w_revNext  = w_revSum[COST_W] ? '1 : w_revSum[COST_W-1:0];
    w_occNext  = r_occupancy;
    if (w_enterOk) begin
      w_occNext = r_occupancy + OCC_ONE;
    end else if (w_exitOk) begin
      w_occNext = r_occupancy - OCC_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slotState    <= '0;
      r_occupancy    <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_costValid    <= 1'b0;
      r_currentCost  <= '0;
      r_revenueTotal <= '0;
      r_err          <= 1'b0;
      r_errCode      <= ERR_BOTH;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_dur[i] <= '0;
      end
    end else begin
      r_costValid <= w_exitOk;
      r_err       <= w_reject;
      if (w_reject) begin
        r_errCode <= w_errCause;
      end
      if (w_exitOk) begin
        r_currentCost <= w_cost;
      end
      if (bus.clr_revenue) begin
        r_revenueTotal <= '0;
      end else if (w_exitOk) begin
        r_revenueTotal <= w_revNext;
      end
      if (w_enterOk) begin
        r_slotState <= r_slotState | bus.slot_sel;
      end else if (w_exitOk) begin
        r_slotState <= r_slotState & ~bus.slot_sel;
      end
      r_occupancy <= w_occNext;
      r_full      <= (w_occNext == OCC_FULL);
      r_empty     <= (w_occNext == '0);
      // A slot being entered or exited restarts at zero, so a same-cycle tick is dropped.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if ((w_enterOk || w_exitOk) && bus.slot_sel[i]) begin
          r_dur[i] <= '0;
        end else if (bus.tick && r_slotState[i] && (r_dur[i] != DUR_MAX)) begin
          r_dur[i] <= r_dur[i] + DUR_W'(1);
        end
      end
    end
  end

  assign bus.slot_state    = r_slotState;
  assign bus.occupancy     = r_occupancy;
  assign bus.full          = r_full;
  assign bus.empty         = r_empty;
  assign bus.cost_valid    = r_costValid;
  assign bus.current_cost  = r_currentCost;
  assign bus.revenue_total = r_revenueTotal;
  assign bus.err           = r_err;
  assign bus.err_code      = r_errCode;
endmodule

// File: tb/tb_parking_slot_manager.sv
// Directed bench for parking_slot_manager: a vector table on the default build,
// plus short hand-written sequences for saturation and mid-operation reset.
module tb_parking_slot_manager;
  logic clk;
  logic reset;
  int   nCompared;
  int   nMismatched;

  parking_slot_manager_if #(.NUM_SLOTS(3), .COST_W(16)) busM ();
  parking_slot_manager_if #(.NUM_SLOTS(3), .COST_W(16)) busD ();
  parking_slot_manager_if #(.NUM_SLOTS(3), .COST_W(4))  busC ();

  parking_slot_manager #(.NUM_SLOTS(3), .DUR_W(10), .COST_W(16), .RATE(1), .BASE_FEE(0))
    dutM (.clk(clk), .reset(reset), .bus(busM));
  parking_slot_manager #(.NUM_SLOTS(3), .DUR_W(4), .COST_W(16), .RATE(1), .BASE_FEE(0))
    dutD (.clk(clk), .reset(reset), .bus(busD));
  parking_slot_manager #(.NUM_SLOTS(3), .DUR_W(10), .COST_W(4), .RATE(1), .BASE_FEE(0))
    dutC (.clk(clk), .reset(reset), .bus(busC));

  typedef struct {
    logic       en;
    logic       ex;
    logic [2:0] sel;
    logic       tk;
    logic       cl;
    int         reps;
    logic [2:0] st;
    logic [1:0] oc;
    logic       fu;
    logic       em;
    logic       cv;
    logic [15:0] co;
    logic [15:0] rv;
    logic       er;
    logic [1:0] ec;
  } vec_t;

  vec_t vecs[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(logic en, logic ex, logic [2:0] sel, logic tk, logic cl,
                              int reps, logic [2:0] st, logic [1:0] oc, logic fu,
                              logic em, logic cv, logic [15:0] co, logic [15:0] rv,
                              logic er, logic [1:0] ec);
    vec_t v;
    v.en = en; v.ex = ex; v.sel = sel; v.tk = tk; v.cl = cl; v.reps = reps;
    v.st = st; v.oc = oc; v.fu = fu; v.em = em; v.cv = cv;
    v.co = co; v.rv = rv; v.er = er; v.ec = ec;
    return v;
  endfunction

  function automatic logic [63:0] packExp(logic [2:0] st, logic [1:0] oc, logic fu,
                                          logic em, logic cv, logic [15:0] co,
                                          logic [15:0] rv, logic er, logic [1:0] ec);
    return {21'b0, st, oc, fu, em, cv, co, rv, er, ec};
  endfunction

  function automatic logic [63:0] packMain();
    return {21'b0, busM.slot_state, busM.occupancy, busM.full, busM.empty,
            busM.cost_valid, busM.current_cost, busM.revenue_total, busM.err,
            busM.err_code};
  endfunction

  task automatic clearInputs();
    busM.car_enter = 0; busM.car_exit = 0; busM.slot_sel = '0; busM.tick = 0; busM.clr_revenue = 0;
    busD.car_enter = 0; busD.car_exit = 0; busD.slot_sel = '0; busD.tick = 0; busD.clr_revenue = 0;
    busC.car_enter = 0; busC.car_exit = 0; busC.slot_sel = '0; busC.tick = 0; busC.clr_revenue = 0;
  endtask

  // Drive one request on the selected bus (0 main, 1 short-duration, 2 narrow-cost) for one edge.
  task automatic applyStimulus(input int which, input logic en, input logic ex,
                               input logic [2:0] sel, input logic tk, input logic cl);
    if (which == 0) begin
      busM.car_enter = en; busM.car_exit = ex; busM.slot_sel = sel; busM.tick = tk; busM.clr_revenue = cl;
    end else if (which == 1) begin
      busD.car_enter = en; busD.car_exit = ex; busD.slot_sel = sel; busD.tick = tk; busD.clr_revenue = cl;
    end else begin
      busC.car_enter = en; busC.car_exit = ex; busC.slot_sel = sel; busC.tick = tk; busC.clr_revenue = cl;
    end
    @(posedge clk);
    #1;
    clearInputs();
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    reset       = 1'b1;
    clearInputs();

    // fields: en ex sel tk cl reps | st oc fu em cv cost rev err ec
    vecs.push_back(mk(1,0,3'b001,0,0,1, 3'b001,2'd1,0,0,0,16'd0,16'd0,0,2'd0));
    vecs.push_back(mk(0,0,3'b000,1,0,5, 3'b001,2'd1,0,0,0,16'd0,16'd0,0,2'd0));
    vecs.push_back(mk(0,1,3'b001,0,0,1, 3'b000,2'd0,0,1,1,16'd5,16'd5,0,2'd0));
    vecs.push_back(mk(1,0,3'b001,0,0,1, 3'b001,2'd1,0,0,0,16'd5,16'd5,0,2'd0));
    vecs.push_back(mk(1,0,3'b010,0,0,1, 3'b011,2'd2,0,0,0,16'd5,16'd5,0,2'd0));
    vecs.push_back(mk(1,0,3'b100,0,0,1, 3'b111,2'd3,1,0,0,16'd5,16'd5,0,2'd0));
    vecs.push_back(mk(1,0,3'b010,0,0,1, 3'b111,2'd3,1,0,0,16'd5,16'd5,1,2'd2));
    vecs.push_back(mk(0,1,3'b100,0,0,1, 3'b011,2'd2,0,0,1,16'd0,16'd5,0,2'd2));
    vecs.push_back(mk(0,1,3'b100,0,0,1, 3'b011,2'd2,0,0,0,16'd0,16'd5,1,2'd3));
    vecs.push_back(mk(1,1,3'b001,0,0,1, 3'b011,2'd2,0,0,0,16'd0,16'd5,1,2'd0));
    vecs.push_back(mk(0,1,3'b011,0,0,1, 3'b011,2'd2,0,0,0,16'd0,16'd5,1,2'd1));
    vecs.push_back(mk(1,0,3'b000,0,0,1, 3'b011,2'd2,0,0,0,16'd0,16'd5,1,2'd1));
    vecs.push_back(mk(0,0,3'b000,0,0,1, 3'b011,2'd2,0,0,0,16'd0,16'd5,0,2'd1));
    vecs.push_back(mk(1,1,3'b000,0,0,1, 3'b011,2'd2,0,0,0,16'd0,16'd5,1,2'd0));
    vecs.push_back(mk(1,0,3'b011,0,0,1, 3'b011,2'd2,0,0,0,16'd0,16'd5,1,2'd1));
    vecs.push_back(mk(0,0,3'b000,1,0,7, 3'b011,2'd2,0,0,0,16'd0,16'd5,0,2'd1));
    vecs.push_back(mk(0,1,3'b001,1,0,1, 3'b010,2'd1,0,0,1,16'd7,16'd12,0,2'd1));
    vecs.push_back(mk(1,0,3'b001,1,0,1, 3'b011,2'd2,0,0,0,16'd7,16'd12,0,2'd1));
    vecs.push_back(mk(0,1,3'b001,0,0,1, 3'b010,2'd1,0,0,1,16'd0,16'd12,0,2'd1));
    vecs.push_back(mk(0,1,3'b010,0,1,1, 3'b000,2'd0,0,1,1,16'd9,16'd0,0,2'd1));
    vecs.push_back(mk(1,0,3'b100,0,0,1, 3'b100,2'd1,0,0,0,16'd9,16'd0,0,2'd1));
    vecs.push_back(mk(0,0,3'b000,1,0,3, 3'b100,2'd1,0,0,0,16'd9,16'd0,0,2'd1));
    vecs.push_back(mk(0,1,3'b100,0,0,1, 3'b000,2'd0,0,1,1,16'd3,16'd3,0,2'd1));
    vecs.push_back(mk(1,0,3'b001,0,0,1, 3'b001,2'd1,0,0,0,16'd3,16'd3,0,2'd1));

    #2 reset = 1'b0;
    #1 checkOutput("resetAsync", packMain(), packExp(0,0,0,1,0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 checkOutput("idleAfterReset", packMain(), packExp(0,0,0,1,0,0,0,0,0));

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        applyStimulus(0, vecs[i].en, vecs[i].ex, vecs[i].sel, vecs[i].tk, vecs[i].cl);
      end
      checkOutput($sformatf("vec%0d", i), packMain(),
                  packExp(vecs[i].st, vecs[i].oc, vecs[i].fu, vecs[i].em, vecs[i].cv,
                          vecs[i].co, vecs[i].rv, vecs[i].er, vecs[i].ec));
    end

    // 4-bit duration counter stops at 15 ticks.
    applyStimulus(1, 1, 0, 3'b001, 0, 0);
    repeat (20) applyStimulus(1, 0, 0, 3'b000, 1, 0);
    applyStimulus(1, 0, 1, 3'b001, 0, 0);
    checkOutput("durSat", {31'b0, busD.cost_valid, busD.current_cost, busD.revenue_total},
                {31'b0, 1'b1, 16'd15, 16'd15});

    // 4-bit fee and revenue saturate at 15.
    applyStimulus(2, 1, 0, 3'b010, 0, 0);
    repeat (12) applyStimulus(2, 0, 0, 3'b000, 1, 0);
    applyStimulus(2, 0, 1, 3'b010, 0, 0);
    checkOutput("rev12", {55'b0, busC.cost_valid, busC.current_cost, busC.revenue_total},
                {55'b0, 1'b1, 4'd12, 4'd12});
    applyStimulus(2, 1, 0, 3'b010, 0, 0);
    repeat (9) applyStimulus(2, 0, 0, 3'b000, 1, 0);
    applyStimulus(2, 0, 1, 3'b010, 0, 0);
    checkOutput("revSat", {55'b0, busC.cost_valid, busC.current_cost, busC.revenue_total},
                {55'b0, 1'b1, 4'd9, 4'd15});
    applyStimulus(2, 1, 0, 3'b100, 0, 0);
    repeat (20) applyStimulus(2, 0, 0, 3'b000, 1, 0);
    applyStimulus(2, 0, 1, 3'b100, 0, 0);
    checkOutput("feeSat", {55'b0, busC.cost_valid, busC.current_cost, busC.revenue_total},
                {55'b0, 1'b1, 4'd15, 4'd15});

    // Slot 001 is occupied on the main build; reset drops mid-cycle with an exit in flight.
    busM.car_exit = 1'b1;
    busM.slot_sel = 3'b001;
    #2 reset = 1'b0;
    #1 checkOutput("resetMidOp", packMain(), packExp(0,0,0,1,0,0,0,0,0));
    @(posedge clk);
    #1 reset = 1'b1;
    clearInputs();
    #1 checkOutput("afterResetRelease", packMain(), packExp(0,0,0,1,0,0,0,0,0));
    applyStimulus(0, 0, 1, 3'b001, 0, 0);
    checkOutput("exitAfterReset", packMain(), packExp(0,0,0,1,0,0,0,1,3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
